// File: rtl/uart_fifo_param_if.sv
// rtl/uart_fifo_param_if.sv - host-side push/pop handshake of the buffered UART
interface uart_fifo_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] TX_REG;
  logic                 PUSH_TX;
  logic                 TX_FULL;
  logic [LW-1:0]        TX_LEVEL;
  logic                 TX_IDLE;
  logic [DATA_BITS-1:0] RX_REG;
  logic                 RX_PERR;
  logic                 RX_FERR;
  logic                 RX_EMPTY;
  logic [LW-1:0]        RX_LEVEL;
  logic                 POP_RX;
  logic                 RX_OVERRUN;
  logic                 CLR_OVERRUN;

  modport master (
    output TX_REG, PUSH_TX, POP_RX, CLR_OVERRUN,
    input  TX_FULL, TX_LEVEL, TX_IDLE, RX_REG, RX_PERR, RX_FERR,
           RX_EMPTY, RX_LEVEL, RX_OVERRUN
  );

  modport slave (
    input  TX_REG, PUSH_TX, POP_RX, CLR_OVERRUN,
    output TX_FULL, TX_LEVEL, TX_IDLE, RX_REG, RX_PERR, RX_FERR,
           RX_EMPTY, RX_LEVEL, RX_OVERRUN
  );
endinterface

// File: rtl/uart_fifo_param.sv
// rtl/uart_fifo_param.sv - runtime-configurable buffered UART with show-ahead TX/RX FIFOs
// Frame format is latched per frame on each path; RX reports parity/framing errors per word.

module uart_fifo_param_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_q];
  assign level   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module uart_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             UART_SRC_CK,
  input  logic             UART_RST_N,
  input  logic [DIV_W-1:0] BAUD_DIV,
  input  logic             PARITY_EN,
  input  logic             PARITY_ODD,
  input  logic             TWO_STOP,
  output logic             TX_LINE,
  input  logic             RX_LINE,
  uart_fifo_param_if.slave host
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DB_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_PAR, TXS_STOP} tx_state_t;
  typedef enum logic [2:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_PAR, RXS_STOP, RXS_WAIT} rx_state_t;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge UART_SRC_CK or negedge UART_RST_N) begin
    if (!UART_RST_N) rst_sync_q <= '0;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  assign tick  = (div_q == '0);
  assign div_d = tick ? BAUD_DIV : div_q - 1'b1;
  always_ff @(posedge UART_SRC_CK or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  logic [DATA_BITS-1:0] txf_q;
  logic                 txf_empty, txf_full, tx_load;
  logic [LW-1:0]        txf_level;
  tx_state_t            tx_st_q;
  logic [OW-1:0]        tx_tcnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q, tx_pen_q, tx_two_q, tx_stop2_q, tx_line_q;
  logic                 tx_bit_end, tx_last_stop;

  uart_fifo_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(UART_SRC_CK), .rst_n(rst_n), .push(host.PUSH_TX), .pop(tx_load),
    .wdata(host.TX_REG), .rdata(txf_q), .full(txf_full), .empty(txf_empty),
    .level(txf_level)
  );

  assign tx_bit_end   = tick && (tx_tcnt_q == OS_LAST);
  assign tx_last_stop = (tx_st_q == TXS_STOP) && (!tx_two_q || tx_stop2_q);
  // Pending data chains straight from the last stop bit into the next start bit.
  assign tx_load = !txf_empty &&
                   ((tick && tx_st_q == TXS_IDLE) || (tx_bit_end && tx_last_stop));

  always_ff @(posedge UART_SRC_CK or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q    <= TXS_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_line_q  <= 1'b1;
    end else if (tx_load) begin
      tx_st_q    <= TXS_START;
      tx_line_q  <= 1'b0;
      tx_tcnt_q  <= '0;
      tx_sh_q    <= txf_q;
      tx_par_q   <= ^txf_q ^ PARITY_ODD;
      tx_pen_q   <= PARITY_EN;
      tx_two_q   <= TWO_STOP;
      tx_stop2_q <= 1'b0;
    end else if (tick && tx_st_q != TXS_IDLE) begin
      if (tx_tcnt_q != OS_LAST) begin
        tx_tcnt_q <= tx_tcnt_q + 1'b1;
      end else begin
        tx_tcnt_q <= '0;
        case (tx_st_q)
          TXS_START: begin
            tx_st_q   <= TXS_DATA;
            tx_line_q <= tx_sh_q[0];
            tx_bit_q  <= '0;
          end
          TXS_DATA: begin
            if (tx_bit_q == DB_LAST) begin
              tx_st_q   <= tx_pen_q ? TXS_PAR : TXS_STOP;
              tx_line_q <= tx_pen_q ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q  <= tx_bit_q + 1'b1;
              tx_sh_q   <= tx_sh_q >> 1;
              tx_line_q <= tx_sh_q[1];
            end
          end
          TXS_PAR: begin
            tx_st_q   <= TXS_STOP;
            tx_line_q <= 1'b1;
          end
          TXS_STOP: begin
            if (!tx_last_stop) tx_stop2_q <= 1'b1;
            else               tx_st_q    <= TXS_IDLE;
            tx_line_q <= 1'b1;
          end
          default: begin
            tx_st_q   <= TXS_IDLE;
            tx_line_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TX_LINE       = tx_line_q;
  assign host.TX_FULL  = txf_full;
  assign host.TX_LEVEL = txf_level;
  assign host.TX_IDLE  = txf_empty && (tx_st_q == TXS_IDLE);

  logic [1:0]           rx_sync_q;
  logic                 rx_s, rx_prev_q;
  rx_state_t            rx_st_q;
  logic [OW-1:0]        rx_tcnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_acc_q, rx_perr_q, rx_pen_q, rx_odd_q, rx_ovr_q;
  logic                 rx_bit_end, rx_wr, rx_drop, rxf_full, rxf_empty;
  logic [DATA_BITS+1:0] rxf_q;
  logic [LW-1:0]        rxf_level;

  assign rx_s       = rx_sync_q[1];
  assign rx_bit_end = tick && (rx_tcnt_q == OS_LAST);
  assign rx_wr      = (rx_st_q == RXS_STOP) && rx_bit_end;
  assign rx_drop    = rx_wr && rxf_full && !host.POP_RX;

  uart_fifo_param_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(UART_SRC_CK), .rst_n(rst_n), .push(rx_wr), .pop(host.POP_RX),
    .wdata({rx_sh_q, rx_perr_q, !rx_s}), .rdata(rxf_q), .full(rxf_full),
    .empty(rxf_empty), .level(rxf_level)
  );

  always_ff @(posedge UART_SRC_CK or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RXS_IDLE;
      rx_tcnt_q <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_acc_q  <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_pen_q  <= 1'b0;
      rx_odd_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], RX_LINE};
      rx_prev_q <= rx_s;
      if (rx_drop)               rx_ovr_q <= 1'b1;
      else if (host.CLR_OVERRUN) rx_ovr_q <= 1'b0;
      if (tick && rx_st_q inside {RXS_DATA, RXS_PAR, RXS_STOP})
        rx_tcnt_q <= (rx_tcnt_q == OS_LAST) ? '0 : rx_tcnt_q + 1'b1;
      case (rx_st_q)
        RXS_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_st_q   <= RXS_START;
            rx_tcnt_q <= '0;
            rx_pen_q  <= PARITY_EN;
            rx_odd_q  <= PARITY_ODD;
            rx_perr_q <= 1'b0;
            rx_acc_q  <= 1'b0;
          end
        end
        RXS_START: begin
          if (tick) begin
            if (rx_tcnt_q == OS_HALF) begin
              rx_tcnt_q <= '0;
              rx_bit_q  <= '0;
              rx_st_q   <= rx_s ? RXS_IDLE : RXS_DATA;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 1'b1;
            end
          end
        end
        RXS_DATA: begin
          if (rx_bit_end) begin
            rx_sh_q  <= {rx_s, rx_sh_q[DATA_BITS-1:1]};
            rx_acc_q <= rx_acc_q ^ rx_s;
            if (rx_bit_q == DB_LAST) rx_st_q  <= rx_pen_q ? RXS_PAR : RXS_STOP;
            else                     rx_bit_q <= rx_bit_q + 1'b1;
          end
        end
        RXS_PAR: begin
          if (rx_bit_end) begin
            rx_perr_q <= rx_s != (rx_acc_q ^ rx_odd_q);
            rx_st_q   <= RXS_STOP;
          end
        end
        RXS_STOP: begin
          // A low stop bit means the line may still be held low; re-arm only once it idles high.
          if (rx_bit_end) rx_st_q <= rx_s ? RXS_IDLE : RXS_WAIT;
        end
        RXS_WAIT: begin
          if (rx_s) rx_st_q <= RXS_IDLE;
        end
        default: rx_st_q <= RXS_IDLE;
      endcase
    end
  end

  assign host.RX_REG     = rxf_q[DATA_BITS+1:2];
  assign host.RX_PERR    = rxf_q[1];
  assign host.RX_FERR    = rxf_q[0];
  assign host.RX_EMPTY   = rxf_empty;
  assign host.RX_LEVEL   = rxf_level;
  assign host.RX_OVERRUN = rx_ovr_q;
endmodule

// File: tb/tb_uart_fifo_param.sv
// tb/tb_uart_fifo_param.sv - directed self-checking bench for uart_fifo_param
module tb_uart_fifo_param;
  localparam int DEPTH = 4;
  localparam int BIT   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
  logic        rx_drv = 1'b1, loop = 1'b0;
  logic        tx_line, rx_line;
  int          total = 0, bad = 0;

  uart_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) u_if ();

  assign rx_line = loop ? tx_line : rx_drv;

  uart_fifo_param #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .UART_SRC_CK(clk), .UART_RST_N(rst_n), .BAUD_DIV(baud_div),
    .PARITY_EN(par_en), .PARITY_ODD(par_odd), .TWO_STOP(two_stop),
    .TX_LINE(tx_line), .RX_LINE(rx_line), .host(u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    u_if.TX_REG  = d;
    u_if.PUSH_TX = 1'b1;
    @(negedge clk);
    u_if.PUSH_TX = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge clk);
    u_if.POP_RX = 1'b1;
    @(negedge clk);
    u_if.POP_RX = 1'b0;
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (tx_line && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_line, 1'b0);
  endtask

  // Pushes one word and checks every bit mid-period plus the total frame length.
  task automatic tx_frame(input string tag, input logic [7:0] d, input logic pbit, input int len);
    int el;
    push_tx(d);
    wait_tx_low({tag, "_start_seen"});
    repeat (32) @(negedge clk);
    el = 32;
    check({tag, "_startbit"}, tx_line, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (BIT) @(negedge clk);
      el += BIT;
      check($sformatf("%s_d%0d", tag, k), tx_line, d[k]);
    end
    if (par_en) begin
      repeat (BIT) @(negedge clk);
      el += BIT;
      check({tag, "_parity"}, tx_line, pbit);
    end
    repeat (BIT) @(negedge clk);
    el += BIT;
    check({tag, "_stop"}, tx_line, 1'b1);
    while (!u_if.TX_IDLE && el < 2000) begin
      @(negedge clk);
      el++;
    end
    check({tag, "_len"}, el, len);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pbit, input logic sbit);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = d[k];
      repeat (BIT) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = pbit;
      repeat (BIT) @(negedge clk);
    end
    rx_drv = sbit;
    repeat (BIT) @(negedge clk);
    if (!sbit) repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_data"}, u_if.RX_REG, d);
    check({tag, "_perr"}, u_if.RX_PERR, pe);
    check({tag, "_ferr"}, u_if.RX_FERR, fe);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    u_if.TX_REG = '0;
    u_if.PUSH_TX = 1'b0;
    u_if.POP_RX = 1'b0;
    u_if.CLR_OVERRUN = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_tx_line", tx_line, 1'b1);
    check("rst_tx_full", u_if.TX_FULL, 1'b0);
    check("rst_tx_idle", u_if.TX_IDLE, 1'b1);
    check("rst_tx_level", u_if.TX_LEVEL, 0);
    check("rst_rx_empty", u_if.RX_EMPTY, 1'b1);
    check("rst_rx_level", u_if.RX_LEVEL, 0);
    check("rst_rx_reg", {u_if.RX_REG, u_if.RX_PERR, u_if.RX_FERR}, 0);
    check("rst_overrun", u_if.RX_OVERRUN, 1'b0);

    tx_frame("tx8n1", 8'hA5, 1'b0, 640);
    par_en = 1'b1; two_stop = 1'b1;
    tx_frame("tx8e2", 8'hA5, 1'b0, 768);
    par_odd = 1'b1;
    tx_frame("tx8o2", 8'hA5, 1'b1, 768);
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;

    loop = 1'b1;
    push_tx(8'h00);
    push_tx(8'hFF);
    push_tx(8'h3C);
    n = 0;
    while (u_if.RX_LEVEL != 3 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("loop_level", u_if.RX_LEVEL, 3);
    check_head("loop0", 8'h00, 1'b0, 1'b0);
    pop_rx();
    check_head("loop1", 8'hFF, 1'b0, 1'b0);
    pop_rx();
    check_head("loop2", 8'h3C, 1'b0, 1'b0);
    pop_rx();
    check("loop_empty", u_if.RX_EMPTY, 1'b1);
    repeat (BIT) @(negedge clk);
    loop = 1'b0;

    par_en = 1'b1;
    send_rx(8'h5A, 1'b1, 1'b1);
    send_rx(8'h33, 1'b0, 1'b0);
    send_rx(8'h81, 1'b0, 1'b1);
    check("err_level", u_if.RX_LEVEL, 3);
    check_head("err_par", 8'h5A, 1'b1, 1'b0);
    pop_rx();
    check_head("err_frm", 8'h33, 1'b0, 1'b1);
    pop_rx();
    check_head("err_resume", 8'h81, 1'b0, 1'b0);
    pop_rx();
    par_en = 1'b0;

    send_rx(8'h11, 1'b0, 1'b1);
    send_rx(8'h22, 1'b0, 1'b1);
    send_rx(8'h33, 1'b0, 1'b1);
    send_rx(8'h44, 1'b0, 1'b1);
    check("ovr_before", u_if.RX_OVERRUN, 1'b0);
    send_rx(8'h55, 1'b0, 1'b1);
    check("ovr_level", u_if.RX_LEVEL, 4);
    check("ovr_flag", u_if.RX_OVERRUN, 1'b1);
    check("ovr_head", u_if.RX_REG, 8'h11);
    pop_rx();
    pop_rx();
    pop_rx();
    check("ovr_last", u_if.RX_REG, 8'h44);
    pop_rx();
    check("ovr_empty", u_if.RX_EMPTY, 1'b1);
    check("ovr_sticky", u_if.RX_OVERRUN, 1'b1);
    @(negedge clk);
    u_if.CLR_OVERRUN = 1'b1;
    @(negedge clk);
    u_if.CLR_OVERRUN = 1'b0;
    check("ovr_clear", u_if.RX_OVERRUN, 1'b0);

    push_tx(8'h01);
    wait_tx_low("full_first_start");
    for (int k = 0; k < 5; k++) begin
      u_if.TX_REG  = 8'h10 + 8'(k);
      u_if.PUSH_TX = 1'b1;
      @(negedge clk);
    end
    u_if.PUSH_TX = 1'b0;
    check("tx_full_level", u_if.TX_LEVEL, 4);
    check("tx_full_flag", u_if.TX_FULL, 1'b1);

    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_empty", u_if.RX_EMPTY, 1'b1);
    check("glitch_level", u_if.RX_LEVEL, 0);

    @(negedge clk);
    wait_tx_low("rst_mid_low");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_line", tx_line, 1'b1);
    check("rst_mid_txlvl", u_if.TX_LEVEL, 0);
    check("rst_mid_txidle", u_if.TX_IDLE, 1'b1);
    check("rst_mid_rxempty", u_if.RX_EMPTY, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_after_line", tx_line, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
